miner_work_csr: RTL and testbench

Host-facing work/result register block for the mining datapath. It sits directly downstream of the PCIe hard IP's Avalon-MM BAR master. The host writes a SHA-256 midstate, header tail and starting nonce through it; on GO the block hands a snapshotted work unit to the hashing core. It also queues nonces returned by the core in a small FIFO that the host drains by register reads, with an optional level interrupt.

---
 rtl/miner_work_csr_if.sv | 19 +
 rtl/miner_work_csr.sv | 155 +++++++++++++++
 tb/tb_miner_work_csr.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_work_csr_if.sv
// Avalon-MM slave bus between the PCIe BAR master and the work/result CSR block.
interface miner_work_csr_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/miner_work_csr.sv
// Host work/result CSR block: staging registers snapshotted into a work unit
// on GO, plus a small nonce result FIFO drained by register reads.
module miner_work_csr #(
  parameter int          NONCE_FIFO_DEPTH = 4,
  parameter logic [31:0] ID_VALUE         = 32'h4D494E31
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  miner_work_csr_if.slave       avs,
  output logic                  work_valid,
  input  logic                  work_ready,
  output logic [255:0]          work_midstate,
  output logic [95:0]           work_data,
  output logic [31:0]           work_nonce_start,
  input  logic                  result_valid,
  input  logic [31:0]           result_nonce,
  input  logic                  core_busy,
  output logic                  irq
);

  localparam int AW = (NONCE_FIFO_DEPTH > 1) ? $clog2(NONCE_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NONCE_FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [11:0][31:0]                  stage;
  logic [NONCE_FIFO_DEPTH-1:0][31:0]  mem;
  logic [AW-1:0]                      wr_ptr, rd_ptr;
  logic [CW-1:0]                      count;
  logic [0:0]                         state;
  logic                               irq_en, ovf, go_rej;
  logic [31:0]                        rd_mux;

  // Bus decode: CTRL strobes are only meaningful for the cycle of the write
  logic ctrl_wr, go, fifo_clr, sticky_clr;
  logic fifo_empty, fifo_full, pop, push, ovf_set, grj_set;

  assign ctrl_wr    = avs.avs_write && (avs.avs_address == 4'd12);
  assign go         = ctrl_wr && avs.avs_writedata[0];
  assign fifo_clr   = ctrl_wr && avs.avs_writedata[1];
  assign sticky_clr = ctrl_wr && avs.avs_writedata[3];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = avs.avs_read && (avs.avs_address == 4'd14) && !fifo_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push
  assign push       = result_valid && !fifo_clr && (!fifo_full || pop);
  assign ovf_set    = result_valid && !fifo_clr && fifo_full && !pop;
  assign grj_set    = go && (state == ST_PENDING);

  // Staging registers: writable in every handoff state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stage <= '0;
    end else begin
      for (int i = 0; i < 12; i++)
        if (avs.avs_write && (avs.avs_address == 4'(i))) stage[i] <= avs.avs_writedata;
    end
  end

  // Handoff FSM: snapshot staging on GO, hold until the core accepts
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state            <= ST_IDLE;
      work_valid       <= 1'b0;
      work_midstate    <= '0;
      work_data        <= '0;
      work_nonce_start <= '0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          work_midstate    <= stage[7:0];
          work_data        <= stage[10:8];
          work_nonce_start <= stage[11];
          work_valid       <= 1'b1;
          state            <= ST_PENDING;
        end
        ST_PENDING: if (work_valid && work_ready) begin
          work_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= result_nonce;
  end

  // Result FIFO pointers and occupancy; clear beats any same-cycle push/pop
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control/sticky state: a set event outranks a same-cycle STICKY_CLR
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      go_rej <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= avs.avs_writedata[2];
      ovf    <= ovf_set ? 1'b1 : (sticky_clr ? 1'b0 : ovf);
      go_rej <= grj_set ? 1'b1 : (sticky_clr ? 1'b0 : go_rej);
      irq    <= irq_en && !fifo_empty;
    end
  end

  // Read mux, evaluated on the pre-edge state of the read cycle
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 12; i++)
      if (avs.avs_address == 4'(i)) rd_mux = stage[i];
    case (avs.avs_address)
      4'd13: rd_mux = {16'd0, 8'(count), 1'b0, irq_en, go_rej, ovf,
                       fifo_full, fifo_empty, core_busy, work_valid};
      4'd14: rd_mux = fifo_empty ? 32'hFFFF_FFFF : mem[rd_ptr];
      4'd15: rd_mux = ID_VALUE;
      default: ;
    endcase
  end

  // Fixed one-cycle read response
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_miner_work_csr.sv
// Randomized self-checking bench for miner_work_csr against a transaction-level
// model (staging arrays, a nonce queue and a few flags).
module tb_miner_work_csr;
  localparam int D = 4;
  localparam logic [31:0] ID = 32'h4D494E31;

  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic         work_valid, work_ready, result_valid, core_busy, irq;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  work_nonce_start, result_nonce;

  miner_work_csr_if bus ();

  miner_work_csr #(.NONCE_FIFO_DEPTH(D), .ID_VALUE(ID)) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .avs              (bus.slave),
    .work_valid       (work_valid),
    .work_ready       (work_ready),
    .work_midstate    (work_midstate),
    .work_data        (work_data),
    .work_nonce_start (work_nonce_start),
    .result_valid     (result_valid),
    .result_nonce     (result_nonce),
    .core_busy        (core_busy),
    .irq              (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_stage [12];
  logic [31:0] m_snap  [12];
  logic [31:0] q [$];
  logic        m_wv, m_ien, m_ovf, m_grj;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 12; i++) begin m_stage[i] = '0; m_snap[i] = '0; end
    q.delete();
    m_wv = 0; m_ien = 0; m_ovf = 0; m_grj = 0;
  endtask

  task automatic idle_in();
    bus.avs_write = 0; bus.avs_read = 0; bus.avs_address = 0; bus.avs_writedata = 0;
    result_valid = 0; result_nonce = 0; work_ready = 0; core_busy = 0;
  endtask

  // One bus cycle: drive at negedge, predict, clock, check at the next negedge
  task automatic cyc(input logic w, input logic [3:0] a, input logic [31:0] wd,
                     input logic r, input logic rv, input logic [31:0] rn, input logic wrdy);
    logic [31:0]  exp_rd;
    logic         exp_irq, pre_wv, go, clr, sclr, pop, ovf_ev, grj_ev;
    logic [255:0] mid;
    logic [95:0]  dat;
    int           sz;
    bus.avs_write = w; bus.avs_address = a; bus.avs_writedata = wd; bus.avs_read = r;
    result_valid = rv; result_nonce = rn; work_ready = wrdy; core_busy = 1'($urandom);
    sz = q.size();
    if (a < 12)       exp_rd = m_stage[a];
    else if (a == 12) exp_rd = 0;
    else if (a == 13) exp_rd = {16'd0, 8'(sz), 1'b0, m_ien, m_grj, m_ovf,
                                sz == D, sz == 0, core_busy, m_wv};
    else if (a == 14) exp_rd = (sz != 0) ? q[0] : 32'hFFFF_FFFF;
    else              exp_rd = ID;
    exp_irq = m_ien && (sz != 0);
    go   = w && a == 12 && wd[0];
    clr  = w && a == 12 && wd[1];
    sclr = w && a == 12 && wd[3];
    pre_wv = m_wv; grj_ev = 0; ovf_ev = 0;
    if (pre_wv && wrdy) m_wv = 0;
    if (go) begin
      if (!pre_wv) begin
        for (int i = 0; i < 12; i++) m_snap[i] = m_stage[i];
        m_wv = 1;
      end else grj_ev = 1;
    end
    pop = r && a == 14 && sz != 0;
    if (clr) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (rv) begin
        if (sz == D && !pop) ovf_ev = 1;
        else q.push_back(rn);
      end
    end
    if (sclr) begin m_ovf = 0; m_grj = 0; end
    if (ovf_ev) m_ovf = 1;
    if (grj_ev) m_grj = 1;
    if (w && a == 12) m_ien = wd[2];
    if (w && a < 12) m_stage[a] = wd;
    @(posedge clk_clk); @(negedge clk_clk);
    for (int i = 0; i < 8; i++) mid[32*i +: 32] = m_snap[i];
    for (int i = 0; i < 3; i++) dat[32*i +: 32] = m_snap[8+i];
    chk("readdatavalid", {255'd0, bus.avs_readdatavalid}, {255'd0, r});
    if (r) chk($sformatf("readdata@%0d", a), {224'd0, bus.avs_readdata}, {224'd0, exp_rd});
    chk("work_valid", {255'd0, work_valid}, {255'd0, m_wv});
    chk("work_midstate", work_midstate, mid);
    chk("work_data", {160'd0, work_data}, {160'd0, dat});
    chk("work_nonce_start", {224'd0, work_nonce_start}, {224'd0, m_snap[11]});
    chk("irq", {255'd0, irq}, {255'd0, exp_irq});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(1, a, d, 0, 0, 0, 0); endtask
  task automatic rd(input logic [3:0] a);                       cyc(0, a, 0, 1, 0, 0, 0); endtask
  task automatic push(input logic [31:0] n);                    cyc(0, 0, 0, 0, 1, n, 0); endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rd"},  {224'd0, bus.avs_readdata}, 256'd0);
    chk({tag, "_rdv"}, {255'd0, bus.avs_readdatavalid}, 256'd0);
    chk({tag, "_wv"},  {255'd0, work_valid}, 256'd0);
    chk({tag, "_mid"}, work_midstate, 256'd0);
    chk({tag, "_dat"}, {160'd0, work_data}, 256'd0);
    chk({tag, "_ns"},  {224'd0, work_nonce_start}, 256'd0);
    chk({tag, "_irq"}, {255'd0, irq}, 256'd0);
  endtask

  initial begin
    reset_reset_n = 0;
    idle_in();
    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.avs_write = 1'($urandom); bus.avs_read = 1'($urandom);
      bus.avs_address = 4'($urandom); bus.avs_writedata = $urandom;
      result_valid = 1'($urandom); result_nonce = $urandom;
      work_ready = 1'($urandom); core_busy = 1'($urandom);
      @(negedge clk_clk);
      chk_zero_outs("reset");
    end
    idle_in(); m_reset();
    reset_reset_n = 1;

    rd(15);
    chk("id", {224'd0, bus.avs_readdata}, {224'd0, ID});

    // handoff with core stalled, then late staging write must not leak
    for (int n = 0; n < 12; n++) wr(4'(n), 32'h1000_0000 + n);
    wr(12, 32'h1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    wr(0, 32'hDEAD);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("accept_wv", {255'd0, work_valid}, 256'd0);
    chk("snap_keep", {224'd0, work_midstate[31:0]}, {224'd0, 32'h1000_0000});

    // rejected GO while pending
    wr(12, 32'h1);
    wr(1, $urandom);
    wr(12, 32'h1);
    rd(13);
    chk("go_rej_set", {255'd0, bus.avs_readdata[5]}, {255'd0, 1'b1});
    chk("snap_after_rej", {224'd0, work_midstate[31:0]}, {224'd0, 32'hDEAD});
    wr(12, 32'h8);
    rd(13);
    chk("go_rej_clr", {255'd0, bus.avs_readdata[5]}, 256'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // fill / overflow / drain
    wr(12, 32'h2);
    for (int n = 1; n <= 5; n++) push(n);
    rd(13);
    chk("fill_cnt", {248'd0, bus.avs_readdata[15:8]}, 256'd4);
    chk("fill_full", {255'd0, bus.avs_readdata[3]}, {255'd0, 1'b1});
    chk("fill_ovf", {255'd0, bus.avs_readdata[4]}, {255'd0, 1'b1});
    for (int n = 1; n <= 4; n++) begin
      rd(14);
      chk("pop_order", {224'd0, bus.avs_readdata}, 256'(n));
    end
    rd(14);
    chk("pop_empty", {224'd0, bus.avs_readdata}, {224'd0, 32'hFFFF_FFFF});

    // simultaneous push/pop when full, then clear coincident with push
    for (int n = 1; n <= 4; n++) push(n);
    cyc(0, 14, 0, 1, 1, 32'h9, 0);
    rd(13);
    chk("pp_cnt", {248'd0, bus.avs_readdata[15:8]}, 256'd4);
    for (int i = 0; i < 4; i++) rd(14);
    chk("pp_last", {224'd0, bus.avs_readdata}, 256'h9);
    push(32'h77);
    cyc(1, 12, 32'h2, 0, 1, 32'h55, 0);
    rd(13);
    chk("clr_cnt", {248'd0, bus.avs_readdata[15:8]}, 256'd0);

    // irq timing
    wr(12, 32'hC);
    push(32'hABCD);
    chk("irq_n1", {255'd0, irq}, 256'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("irq_n2", {255'd0, irq}, {255'd0, 1'b1});
    rd(14);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("irq_fall", {255'd0, irq}, 256'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic w, r, rv, wrdy;
      logic [3:0]  a;
      logic [31:0] d;
      int op;
      op = $urandom_range(0, 9);
      w = (op < 4) || (op == 9);
      r = (op >= 4);
      a = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
      if (w && $urandom_range(0, 2) == 0) a = 4'd12;
      d = (a == 12) ? ({$urandom} & 32'hFFFF_FFF5) | ($urandom_range(0, 5) == 0 ? 32'h2 : 32'h0)
                              | ($urandom_range(0, 5) == 0 ? 32'h8 : 32'h0)
                    : $urandom;
      rv = ($urandom_range(0, 2) == 0);
      wrdy = ($urandom_range(0, 3) == 0);
      cyc(w, a, d, r, rv, $urandom, wrdy);
    end

    // asynchronous reset in the middle of a handoff
    wr(12, 32'h1);
    reset_reset_n = 0;
    #1;
    chk("arst_wv", {255'd0, work_valid}, 256'd0);
    chk("arst_mid", work_midstate, 256'd0);
    chk("arst_ns", {224'd0, work_nonce_start}, 256'd0);
    @(negedge clk_clk);
    idle_in(); m_reset();
    reset_reset_n = 1;
    rd(13);
    rd(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
